lsu_stage: RTL
==============

// Module: lsu_stage
// PURPOSE
//  Memory-access stage between execute and commit. Latches one instruction from execute.
//  Loads and stores run over a single-outstanding req/rsp data-memory port.
//  Load data is sign/zero-extended; stores get byte strobes.
//  Hands the instruction's writeback bundle, including mem_result, to commit.
//  valid/ready handshake on both sides.
// PARAMETERS
//  XLEN      32  datapath / address width
//  LSU_OP_W  3   width of lsu_op_i (funct3 encoding: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2)
// PORTS
//  clock           in   1     system clock
//  reset           in   1     asynchronous, active-low reset
//  valid_pre_i     in   1     execute has an instruction
//  ready_pre_o     out  1     stage can accept
//  valid_post_o    out  1     bundle valid to commit
//  ready_post_i    in   1     commit accepts
//  mem_ren_i       in   1     instruction is a load
//  mem_wen_i       in   1     instruction is a store (never both with mem_ren_i)
//  lsu_op_i        in   3     access size/sign
//  alu_result_i    in   XLEN  effective address / ALU result
//  store_data_i    in   XLEN  rs2 value
//  wsel_i,wena_i   in   1     passthrough
//  waddr_i         in   5     passthrough
//  csr_wena_i      in   1     passthrough
//  csr_waddr_i     in   XLEN  passthrough
//  csr_wdata_i     in   XLEN  passthrough
//  dreq_valid_o    out  1     memory request valid
//  dreq_ready_i    in   1     memory accepts request
//  dreq_addr_o     out  XLEN  word-aligned address {addr[31:2],2'b00}
//  dreq_wen_o      out  1     1=write
//  dreq_wdata_o    out  XLEN  lane-shifted store data
//  dreq_wstrb_o    out  4     byte strobes (0 for reads)
//  drsp_valid_i    in   1     response (read data or write ack)
//  drsp_rdata_i    in   XLEN  raw word
//  wsel_o,wena_o,waddr_o,alu_result_o,mem_result_o,csr_wena_o,csr_waddr_o,csr_wdata_o  out  registered bundle to commit
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; valid_post_o=0, dreq_valid_o=0; all bundle/request regs 0.
//  ready_pre_o = (state==IDLE) || (state==DONE && ready_post_i). Accept = valid_pre_i && ready_pre_o.
//  FSM:
//   IDLE -> on accept: latch all inputs; mem op ? REQ : DONE.
//   REQ  -> dreq_valid_o=1, payload stable; dreq_ready_i -> WAIT.
//   WAIT -> drsp_valid_i: load -> mem_result=extended rdata; store -> mem_result=0; -> DONE.
//   DONE -> valid_post_o=1, bundle stable until ready_post_i.
//           Accept in the same cycle => back-to-back (next REQ/DONE), else IDLE.
//  Latency: non-mem = 1 cycle accept->valid_post; mem = 3 cycles min (REQ, WAIT, DONE) with zero-wait memory.
//  drsp_valid_i outside WAIT is ignored. One outstanding request only.
//  Load extraction uses off=addr[1:0]:
//   LB/LBU byte off; LH/LHU half addr[1]; LW whole word.
//   Sign-extend for LB/LH, zero-extend for LBU/LHU.
//  Store: SB wstrb=1<<off, wdata={4{b}}; SH wstrb=addr[1]?4'b1100:4'b0011, wdata={2{h}}; SW wstrb=4'hF.
//  Misalignment: no trap; ignored low bits dropped (LW at 0x...2 reads word 0x...0).
//  Reset mid-transaction: FSM to IDLE immediately; the outstanding response is dropped (bus owner must also reset).
//  Unused lsu_op codes (3,6,7) treated as LW/SW.
// STRUCTURE
//  Shared defines: LSU_OP_* codes, state encodings (IDLE/REQ/WAIT/DONE).
//  One sub-module: lsu_align (combinational: store lane/strobe gen + load extract/extend). Remainder: FSM + bundle regs.
// TESTING
//  ALU op, addr 0x10, wena=1, ready_post=1 -> valid_post next cycle, alu_result_o=0x10, no dreq_valid_o.
//  LB addr 0x8000_0003, rdata 0x80AB_CDEF -> dreq_addr 0x8000_0000, mem_result_o=0xFFFF_FF80; LBU -> 0x0000_0080.
//  SH addr 0x102, data 0x1234_BEEF -> wstrb 4'b1100, wdata 0xBEEF_BEEF, wen=1; mem_result_o=0.
//  dreq_ready_i low 5 cycles, then drsp delayed 3 -> request payload stable, ready_pre_o=0 throughout.
//  ready_post_i held low 4 cycles in DONE -> bundle stable, no new accept; then back-to-back accept on release.
//  Assert reset (low) during WAIT -> outputs zero asynchronously; late drsp_valid_i after release ignored.

Source files
------------

// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: access-size codes, FSM states
// and the byte-strobe helper used by the alignment logic.
package lsu_stage_pkg;

    localparam int XLEN     = 32;
    localparam int LSU_OP_W = 3;

    localparam logic [LSU_OP_W-1:0] LSU_OP_B  = 3'd0;
    localparam logic [LSU_OP_W-1:0] LSU_OP_H  = 3'd1;
    localparam logic [LSU_OP_W-1:0] LSU_OP_W_ = 3'd2;
    localparam logic [LSU_OP_W-1:0] LSU_OP_BU = 3'd4;
    localparam logic [LSU_OP_W-1:0] LSU_OP_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Unknown size codes fall back to a full-word strobe.
    function automatic logic [3:0] store_strobe(input logic [LSU_OP_W-1:0] op,
                                                input logic [1:0]          off);
        logic [3:0] strb;
        case (op)
            LSU_OP_B: strb = 4'b0001 << off;
            LSU_OP_H: strb = off[1] ? 4'b1100 : 4'b0011;
            default:  strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: replicates store data across byte lanes with strobes,
// and extracts/extends load data from the raw memory word.
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic [LSU_OP_W-1:0] st_op_i,
    input  logic [1:0]          st_off_i,
    input  logic [XLEN-1:0]     st_data_i,
    output logic [XLEN-1:0]     st_wdata_o,
    output logic [3:0]          st_wstrb_o,
    input  logic [LSU_OP_W-1:0] ld_op_i,
    input  logic [1:0]          ld_off_i,
    input  logic [XLEN-1:0]     ld_rdata_i,
    output logic [XLEN-1:0]     ld_data_o
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store lanes: narrow data is replicated so the strobe alone selects the lane.
    always_comb begin
        st_wstrb_o = store_strobe(st_op_i, st_off_i);
        case (st_op_i)
            LSU_OP_B: st_wdata_o = {4{st_data_i[7:0]}};
            LSU_OP_H: st_wdata_o = {2{st_data_i[15:0]}};
            default:  st_wdata_o = st_data_i;
        endcase
    end

    // Load extraction: byte by full offset, half by addr[1], then extend.
    always_comb begin
        case (ld_off_i)
            2'd0:    ld_byte_s = ld_rdata_i[7:0];
            2'd1:    ld_byte_s = ld_rdata_i[15:8];
            2'd2:    ld_byte_s = ld_rdata_i[23:16];
            default: ld_byte_s = ld_rdata_i[31:24];
        endcase
        if (ld_off_i[1]) begin
            ld_half_s = ld_rdata_i[31:16];
        end else begin
            ld_half_s = ld_rdata_i[15:0];
        end
        case (ld_op_i)
            LSU_OP_B:  ld_data_o = {{24{ld_byte_s[7]}}, ld_byte_s};
            LSU_OP_BU: ld_data_o = {24'h00_0000, ld_byte_s};
            LSU_OP_H:  ld_data_o = {{16{ld_half_s[15]}}, ld_half_s};
            LSU_OP_HU: ld_data_o = {16'h0000, ld_half_s};
            default:   ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access stage: latches one instruction, runs a single-outstanding
// data-memory transaction for loads/stores, and hands the bundle to commit.
module lsu_stage
    import lsu_stage_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                valid_pre_i,
    output logic                ready_pre_o,
    output logic                valid_post_o,
    input  logic                ready_post_i,
    input  logic                mem_ren_i,
    input  logic                mem_wen_i,
    input  logic [LSU_OP_W-1:0] lsu_op_i,
    input  logic [XLEN-1:0]     alu_result_i,
    input  logic [XLEN-1:0]     store_data_i,
    input  logic                wsel_i,
    input  logic                wena_i,
    input  logic [4:0]          waddr_i,
    input  logic                csr_wena_i,
    input  logic [XLEN-1:0]     csr_waddr_i,
    input  logic [XLEN-1:0]     csr_wdata_i,
    output logic                dreq_valid_o,
    input  logic                dreq_ready_i,
    output logic [XLEN-1:0]     dreq_addr_o,
    output logic                dreq_wen_o,
    output logic [XLEN-1:0]     dreq_wdata_o,
    output logic [3:0]          dreq_wstrb_o,
    input  logic                drsp_valid_i,
    input  logic [XLEN-1:0]     drsp_rdata_i,
    output logic                wsel_o,
    output logic                wena_o,
    output logic [4:0]          waddr_o,
    output logic [XLEN-1:0]     alu_result_o,
    output logic [XLEN-1:0]     mem_result_o,
    output logic                csr_wena_o,
    output logic [XLEN-1:0]     csr_waddr_o,
    output logic [XLEN-1:0]     csr_wdata_o
);

    lsu_state_e          state_q, state_d;
    logic                mem_ren_q;
    logic [LSU_OP_W-1:0] op_q;
    logic                accept_s;
    logic                is_mem_s;
    logic [XLEN-1:0]     st_wdata_s;
    logic [3:0]          st_wstrb_s;
    logic [XLEN-1:0]     ld_data_s;

    assign accept_s = valid_pre_i && ready_pre_o;
    assign is_mem_s = mem_ren_i || mem_wen_i;

    lsu_align u_align (
        .st_op_i    (lsu_op_i),
        .st_off_i   (alu_result_i[1:0]),
        .st_data_i  (store_data_i),
        .st_wdata_o (st_wdata_s),
        .st_wstrb_o (st_wstrb_s),
        .ld_op_i    (op_q),
        .ld_off_i   (alu_result_o[1:0]),
        .ld_rdata_i (drsp_rdata_i),
        .ld_data_o  (ld_data_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE can accept the next instruction in the release cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = is_mem_s ? ST_REQ : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dreq_ready_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (drsp_valid_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_d = is_mem_s ? ST_REQ : ST_DONE;
                end else if (ready_post_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        dreq_valid_o = 1'b0;
        valid_post_o = 1'b0;
        ready_pre_o  = 1'b0;
        case (state_q)
            ST_IDLE: ready_pre_o = 1'b1;
            ST_REQ:  dreq_valid_o = 1'b1;
            ST_WAIT: ready_pre_o = 1'b0;
            ST_DONE: begin
                valid_post_o = 1'b1;
                ready_pre_o  = ready_post_i;
            end
            default: ready_pre_o = 1'b0;
        endcase
    end

    // Bundle and request payload: captured on accept, result filled on response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ren_q    <= 1'b0;
            op_q         <= 3'd0;
            wsel_o       <= 1'b0;
            wena_o       <= 1'b0;
            waddr_o      <= 5'd0;
            alu_result_o <= 32'h0;
            mem_result_o <= 32'h0;
            csr_wena_o   <= 1'b0;
            csr_waddr_o  <= 32'h0;
            csr_wdata_o  <= 32'h0;
            dreq_addr_o  <= 32'h0;
            dreq_wen_o   <= 1'b0;
            dreq_wdata_o <= 32'h0;
            dreq_wstrb_o <= 4'h0;
        end else if (accept_s) begin
            mem_ren_q    <= mem_ren_i;
            op_q         <= lsu_op_i;
            wsel_o       <= wsel_i;
            wena_o       <= wena_i;
            waddr_o      <= waddr_i;
            alu_result_o <= alu_result_i;
            mem_result_o <= 32'h0;
            csr_wena_o   <= csr_wena_i;
            csr_waddr_o  <= csr_waddr_i;
            csr_wdata_o  <= csr_wdata_i;
            dreq_addr_o  <= {alu_result_i[XLEN-1:2], 2'b00};
            dreq_wen_o   <= mem_wen_i;
            dreq_wdata_o <= mem_wen_i ? st_wdata_s : 32'h0;
            dreq_wstrb_o <= mem_wen_i ? st_wstrb_s : 4'h0;
        end else if ((state_q == ST_WAIT) && drsp_valid_i) begin
            mem_result_o <= mem_ren_q ? ld_data_s : 32'h0;
        end
    end

endmodule
